// File: rtl/rotate_seq.sv
// -----------------------------------------------------------------------------
// rotate_seq: multi-cycle rotate/shift sequencer for an 8-bit datapath.
//
// Accepts one operation per start handshake (sampled only in IDLE). Each clock
// in RUN performs a single 1-bit step, shamt times. The result, carry-out and
// zero flag are returned together with a one-cycle done pulse.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous, active-high reset
//   start  in   request, sampled only in IDLE
//   op     in   000 ROL, 001 ROR, 010 SHL, 011 SHR, 100 ASR, 101-111 PASS
//   a      in   operand, captured on the accepted start edge
//   shamt  in   step count 0-7, captured on the accepted start edge
//   busy   out  high while in RUN
//   done   out  one-cycle pulse, high while in DONE
//   y      out  result register
//   carry  out  last bit shifted/rotated out
//   zero   out  high when y == 0 (combinational from y)
//
// Optional build macro ROT_SEQ_FAST_EN: ROL/ROR complete in a single cycle
// through combinational rol8/ror8 rotators; SHL/SHR/ASR stay iterative.
// Without the macro no rotator instances are present.
// -----------------------------------------------------------------------------

`ifdef ROT_SEQ_FAST_EN
// Combinational rotate left by amt (0-7).
module rol8 (
  input  logic [7:0] a,
  input  logic [2:0] amt,
  output logic [7:0] y
);
  assign y = (a << amt) | (a >> (4'd8 - {1'b0, amt}));
endmodule

// Combinational rotate right by amt (0-7).
module ror8 (
  input  logic [7:0] a,
  input  logic [2:0] amt,
  output logic [7:0] y
);
  assign y = (a >> amt) | (a << (4'd8 - {1'b0, amt}));
endmodule
`endif

module rotate_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [CNT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_ASR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt;

  // Value loaded into y/carry on an accepted start.
  logic [WIDTH-1:0] load_y;
  logic             load_c;
  // High when the requested op finishes straight from IDLE via the rotators.
  logic             fast_rot;

  // Opcodes 101..111 are PASS; 100 is ASR.
  function automatic logic is_pass(input logic [2:0] o);
    return o[2] & (o[1] | o[0]);
  endfunction

  // One 1-bit step; returns {carry_out, next_y}.
  function automatic logic [WIDTH:0] step_op(input logic [2:0]       o,
                                             input logic [WIDTH-1:0] v,
                                             input logic             c);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    case (o)
      OP_ROL:  step_op = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  step_op = {v[0], v[0], v[WIDTH-1:1]};
      OP_SHL:  step_op = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SHR:  step_op = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_ASR:  step_op = {v[0], sv >>> 1};
      default: step_op = {c, v};
    endcase
  endfunction

`ifdef ROT_SEQ_FAST_EN
  logic [7:0] rol_y;
  logic [7:0] ror_y;

  // The rotators see the operand and count being captured on this edge, so
  // the finished result is written into y at the same moment it is latched.
  rol8 u_rol8 (.a(a), .amt(shamt), .y(rol_y));
  ror8 u_ror8 (.a(a), .amt(shamt), .y(ror_y));

  assign fast_rot = (op == OP_ROL) || (op == OP_ROR);

  // The last bit out of a k-step rotate ends up at y[0] (ROL) or y[7] (ROR).
  always_comb begin
    load_y = a;
    load_c = 1'b0;
    if (op == OP_ROL) begin
      load_y = rol_y;
      load_c = (shamt != '0) & rol_y[0];
    end else if (op == OP_ROR) begin
      load_y = ror_y;
      load_c = (shamt != '0) & ror_y[7];
    end
  end
`else
  assign fast_rot = 1'b0;
  assign load_y   = a;
  assign load_c   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (fast_rot) begin
            state_nx = S_DONE;
          end else if ((shamt != '0) && !is_pass(op)) begin
            state_nx = S_RUN;
          end else begin
            state_nx = S_DONE;
          end
        end
      end
      // The step that takes the counter from 1 to 0 is the last one.
      S_RUN:   if (cnt == CNT_W'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand capture and iterative datapath. y/carry hold outside IDLE-accept
  // and RUN, so the result stays visible until the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y     <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      op_r  <= OP_ROL;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r  <= op;
            cnt   <= shamt;
            y     <= load_y;
            carry <= load_c;
          end
        end
        S_RUN: begin
          {carry, y} <= step_op(op_r, y, carry);
          cnt        <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign zero = (y == '0);

endmodule
